reciprocal_pwl_pipe: RTL and testbench

Pipelined, parametrised piecewise-linear reciprocal approximator for the pseudo-softmax datapath. It is the successor of the fixed 8-bit, 2-segment PWL reciprocal. Width and segment count are generic, and per-segment coefficients are runtime-programmable. The block has valid/ready handshakes on both sides, and the output saturates at zero. It sits between the exponent/sum stage and the normalising multiplier.

---
 rtl/reciprocal_pwl_pipe.sv | 115 +++++++++++
 tb/tb_reciprocal_pwl_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reciprocal_pwl_pipe.sv
// Pipelined piecewise-linear reciprocal: y = C_k - (x >> A_k) - (x >> B_k), saturated at zero.
// Three register stages, a single global advance enable, and a runtime-writable coefficient table.
module reciprocal_pwl_pipe #(
  parameter int W        = 8,
  parameter int SEG_BITS = 1,
  parameter int SHW      = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [W-1:0]        in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W-1:0]        out_data_o,
  output logic                out_clamp_o,
  input  logic                cfg_we_i,
  input  logic [SEG_BITS-1:0] cfg_seg_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [W-1:0]        cfg_wdata_i
);

  localparam int NSEG = 1 << SEG_BITS;

  // Default offsets are 8-bit constants rescaled to W bits (left shift for W > 8, right for W < 8).
  localparam logic [W+7:0] C0_EXT = (W+8)'(8'h33) << W;
  localparam logic [W+7:0] C1_EXT = (W+8)'(8'h09) << W;
  localparam logic [W-1:0] C0_DEF = C0_EXT[W+7:8];
  localparam logic [W-1:0] C1_DEF = C1_EXT[W+7:8];

  logic [W-1:0]   cTab_q [NSEG];
  logic [SHW-1:0] aTab_q [NSEG];
  logic [SHW-1:0] bTab_q [NSEG];

  logic                v1_q, v2_q, v3_q;
  logic [W-1:0]        x1_q, c1_q, t1_q, t2_q, c2_q, data_q;
  logic [SHW-1:0]      a1_q, b1_q;
  logic                clamp_q;
  logic                en;
  logic                accept;
  logic [SEG_BITS-1:0] seg;
  logic [W+1:0]        diff_d;
  logic                clamp_d;
  logic [W-1:0]        data_d;

  assign en          = !v3_q || out_ready_i;
  assign in_ready_o  = en;
  assign accept      = in_valid_i && en;
  assign seg         = in_data_i[W-1 -: SEG_BITS];
  assign out_valid_o = v3_q;
  assign out_data_o  = data_q;
  assign out_clamp_o = clamp_q;

  // Non-negative results never set bit W, so zeroing on either top bit equals zeroing on the sign.
  assign diff_d  = {2'b00, c2_q} - {2'b00, t1_q} - {2'b00, t2_q};
  assign clamp_d = diff_d[W+1];
  assign data_d  = (|diff_d[W+1:W]) ? '0 : diff_d[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        cTab_q[k] <= '0;
        aTab_q[k] <= '0;
        bTab_q[k] <= '0;
      end
      cTab_q[0] <= C0_DEF;
      aTab_q[0] <= SHW'(1);
      bTab_q[0] <= SHW'(3);
      cTab_q[1] <= C1_DEF;
      aTab_q[1] <= SHW'(2);
      bTab_q[1] <= SHW'(4);
    end else if (cfg_we_i) begin
      case (cfg_sel_i)
        2'd0:    cTab_q[cfg_seg_i] <= cfg_wdata_i;
        2'd1:    aTab_q[cfg_seg_i] <= cfg_wdata_i[SHW-1:0];
        2'd2:    bTab_q[cfg_seg_i] <= cfg_wdata_i[SHW-1:0];
        default: ;
      endcase
    end
  end

  // The S1 snapshot reads the table before a same-edge write lands, so that sample sees old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      x1_q    <= '0;
      c1_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      c2_q    <= '0;
      data_q  <= '0;
      clamp_q <= 1'b0;
    end else if (en) begin
      v1_q <= accept;
      x1_q <= in_data_i;
      c1_q <= cTab_q[seg];
      a1_q <= aTab_q[seg];
      b1_q <= bTab_q[seg];
      v2_q <= v1_q;
      t1_q <= x1_q >> a1_q;
      t2_q <= x1_q >> b1_q;
      c2_q <= c1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        data_q  <= data_d;
        clamp_q <= clamp_d;
      end
    end
  end

endmodule

// File: tb/tb_reciprocal_pwl_pipe.sv
// Scoreboard bench for reciprocal_pwl_pipe: a coefficient-table model predicts each accepted sample,
// a negedge monitor pops predictions as results are handed downstream; a W=12 instance gets directed checks.
module tb_reciprocal_pwl_pipe;

  typedef struct {
    int data;
    int clamp;
    int acceptEdge;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       inValid, inReady, outValid, outReady, outClamp, cfgWe;
  logic [7:0] inData, outData, cfgWdata;
  logic [0:0] cfgSeg;
  logic [1:0] cfgSel;

  logic        inValid12, inReady12, outValid12, outReady12, outClamp12, cfgWe12;
  logic [11:0] inData12, outData12, cfgWdata12;
  logic [1:0]  cfgSeg12, cfgSel12;

  int   checks = 0;
  int   errors = 0;
  int   edgeCount = 0;
  bit   latencyMode = 0;
  bit   senderDone = 0;
  bit   prevStall = 0;
  int   heldData = 0;
  int   heldClamp = 0;
  int   mC [2];
  int   mA [2];
  int   mB [2];
  exp_t sbQ [$];
  exp_t popped;

  reciprocal_pwl_pipe #(.W(8), .SEG_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_data_o(outData), .out_clamp_o(outClamp),
    .cfg_we_i(cfgWe), .cfg_seg_i(cfgSeg), .cfg_sel_i(cfgSel), .cfg_wdata_i(cfgWdata)
  );

  reciprocal_pwl_pipe #(.W(12), .SEG_BITS(2)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(inValid12), .in_ready_o(inReady12), .in_data_i(inData12),
    .out_valid_o(outValid12), .out_ready_i(outReady12), .out_data_o(outData12), .out_clamp_o(outClamp12),
    .cfg_we_i(cfgWe12), .cfg_seg_i(cfgSeg12), .cfg_sel_i(cfgSel12), .cfg_wdata_i(cfgWdata12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    mC[0] = 'h33; mA[0] = 1; mB[0] = 3;
    mC[1] = 'h09; mA[1] = 2; mB[1] = 4;
  endtask

  // Reference: evaluate the segment formula with plain integer arithmetic, clamp negatives to zero.
  function automatic exp_t modelResult(input int x);
    exp_t r;
    int   s;
    int   y;
    s = x >> 7;
    y = mC[s] - (x >> mA[s]) - (x >> mB[s]);
    r.data  = (y < 0) ? 0 : y;
    r.clamp = (y < 0) ? 1 : 0;
    r.acceptEdge = edgeCount + 1;
    return r;
  endfunction

  // Predict at the negedge before the accepting edge, then apply any pending table write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inValid && inReady) sbQ.push_back(modelResult(int'(inData)));
      if (cfgWe) begin
        case (cfgSel)
          2'd0: mC[cfgSeg] = int'(cfgWdata);
          2'd1: mA[cfgSeg] = int'(cfgWdata) & 7;
          2'd2: mB[cfgSeg] = int'(cfgWdata) & 7;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", int'(inReady), int'(!(outValid && !outReady)));
      if (prevStall && outValid) begin
        checkOutput("stall_data_hold", int'(outData), heldData);
        checkOutput("stall_clamp_hold", int'(outClamp), heldClamp);
      end
      if (outValid && outReady) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_output", int'(outData), -1);
        end else begin
          popped = sbQ.pop_front();
          checkOutput("out_data", int'(outData), popped.data);
          checkOutput("out_clamp", int'(outClamp), popped.clamp);
          if (latencyMode) checkOutput("latency", edgeCount - popped.acceptEdge, 2);
        end
      end
      prevStall = outValid && !outReady;
      heldData  = int'(outData);
      heldClamp = int'(outClamp);
    end else begin
      prevStall = 0;
    end
  end

  task automatic applyStimulus(input int x);
    bit acc;
    acc = 0;
    inValid = 1'b1;
    inData  = 8'(x);
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
    inValid = 1'b0;
  endtask

  task automatic writeCfg(input int seg, input int sel, input int data);
    cfgWe    = 1'b1;
    cfgSeg   = 1'(seg);
    cfgSel   = 2'(sel);
    cfgWdata = 8'(data);
    @(posedge clk);
    #1;
    cfgWe = 1'b0;
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 300 && sbQ.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drain_pending", sbQ.size(), 0);
  endtask

  task automatic run12(input int x, input int expData, input int expClamp);
    bit seen;
    seen = 0;
    checkOutput("w12_in_ready", int'(inReady12), 1);
    inValid12 = 1'b1;
    inData12  = 12'(x);
    @(posedge clk);
    #1;
    inValid12 = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = outValid12;
    end
    checkOutput("w12_out_valid", int'(seen), 1);
    checkOutput("w12_out_data", int'(outData12), expData);
    checkOutput("w12_out_clamp", int'(outClamp12), expClamp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    inValid = 0; inData = 0; outReady = 1; cfgWe = 0; cfgSeg = 0; cfgSel = 0; cfgWdata = 0;
    inValid12 = 0; inData12 = 0; outReady12 = 1; cfgWe12 = 0; cfgSeg12 = 0; cfgSel12 = 0; cfgWdata12 = 0;
    resetModel();
    #3;
    checkOutput("reset_out_valid", int'(outValid), 0);
    checkOutput("reset_out_data", int'(outData), 0);
    checkOutput("reset_out_clamp", int'(outClamp), 0);
    checkOutput("reset_in_ready", int'(inReady), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back defaults with latency check");
    latencyMode = 1;
    applyStimulus('h00);
    applyStimulus('h20);
    applyStimulus('h40);
    waitIdle();
    latencyMode = 0;

    $display("[TB] clamp cases");
    applyStimulus('h7F);
    applyStimulus('h80);
    waitIdle();

    $display("[TB] coefficient writes");
    writeCfg(1, 0, 'hFF);
    writeCfg(1, 1, 1);
    writeCfg(1, 2, 7);
    applyStimulus('h80);
    waitIdle();
    writeCfg(1, 0, 'h09);
    writeCfg(1, 1, 2);
    writeCfg(1, 2, 4);
    writeCfg(1, 3, 'hAA);
    cfgWe = 1'b1; cfgSeg = 1'b1; cfgSel = 2'd0; cfgWdata = 8'hFF;
    applyStimulus('h80);
    cfgWe = 1'b0;
    applyStimulus('h80);
    waitIdle();

    $display("[TB] random stream with backpressure");
    senderDone = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) writeCfg($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255));
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            @(posedge clk);
            #1;
          end
          applyStimulus($urandom_range(0, 255));
        end
        senderDone = 1;
      end
      begin
        while (!senderDone) begin
          @(posedge clk);
          #1;
          outReady = 1'($urandom_range(0, 1));
        end
      end
    join
    outReady = 1'b1;
    waitIdle();

    $display("[TB] asynchronous reset with samples in flight");
    writeCfg(0, 0, 'h80);
    outReady = 1'b0;
    applyStimulus('h10);
    applyStimulus('h20);
    applyStimulus('h30);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", int'(outValid), 0);
    checkOutput("midreset_out_data", int'(outData), 0);
    checkOutput("midreset_in_ready", int'(inReady), 1);
    sbQ.delete();
    resetModel();
    outReady = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) @(posedge clk);
    #1;
    applyStimulus('h20);
    waitIdle();

    $display("[TB] W=12, SEG_BITS=2 instance");
    run12('h200, 'h1F0, 0);
    run12('hC00, 'h000, 1);
    run12('h400, 'h000, 1);
    run12('h010, 'h326, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
